// File: rtl/camera_packer_pkg.sv
// camera_packer_pkg: shared widths, FSM state type and buffer payload for camera_word_packer.
package camera_packer_pkg;

  localparam int unsigned PIX_W        = 16;
  localparam int unsigned PIX_PER_WORD = 8;
  localparam int unsigned WORD_W       = PIX_W * PIX_PER_WORD;
  localparam int unsigned LANE_W       = $clog2(PIX_PER_WORD);
  localparam int unsigned SHIFT_W      = WORD_W - PIX_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PACK      = 2'd1,
    ST_HOLD_LAST = 2'd2
  } pack_state_t;

  // One output-buffer entry: packed word plus its end-of-frame marker.
  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } axis_word_t;

endpackage

// File: rtl/camera_word_packer_fifo.sv
// word_fifo2: 2-entry FIFO of {last, data}; slot0 is always the head, so the head is a register.
module word_fifo2
  import camera_packer_pkg::*;
(
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            push,
  input  logic [WORD_W:0] push_word,
  input  logic            pop,
  output logic [WORD_W:0] head,
  output logic            full,
  output logic            empty
);

  logic [1:0]      count_q;
  logic [1:0]      count_d;
  logic [WORD_W:0] slot0_q;
  logic [WORD_W:0] slot1_q;
  logic            pop_ok;
  logic            push_ok;

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = slot0_q;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and registered full/empty flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= 2'd0;
      full    <= 1'b0;
      empty   <= 1'b1;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      count_q <= count_d;
      full    <= (count_d == 2'd2);
      empty   <= (count_d == 2'd0);
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) slot0_q <= push_word;
          else                 slot1_q <= push_word;
        end
        2'b01: slot0_q <= slot1_q;
        2'b11: begin
          if (count_q == 2'd1) begin
            slot0_q <= push_word;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= push_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/camera_word_packer.sv
// camera_word_packer: packs 8 RGB565 pixels per 128-bit AXI-Stream word, TLAST on last word of frame.
// Optional build macro CAMERA_PACKER_CHECK_EN: checks every pixel's raster coordinates while packing
// and pulses resync_out on an ordering error; otherwise resync_out is constant 0.
module camera_word_packer
  import camera_packer_pkg::*;
#(
  parameter int unsigned H_PIXELS = 320,
  parameter int unsigned V_LINES  = 180
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [15:0]  pixel_in,
  input  logic         pixel_valid_in,
  input  logic [10:0]  hcount_in,
  input  logic [9:0]   vcount_in,
  output logic [127:0] m_axis_data,
  output logic         m_axis_tlast,
  output logic         m_axis_valid,
  input  logic         m_axis_ready,
  output logic         overflow_out,
  output logic         resync_out,
  output logic         frame_done_out
);

  localparam int unsigned WORDS_PER_FRAME = H_PIXELS * V_LINES / PIX_PER_WORD;
  localparam int unsigned WCNT_W          = $clog2(WORDS_PER_FRAME + 1);

  pack_state_t         state_q;
  pack_state_t         state_d;
  logic [LANE_W-1:0]   lane_q;
  logic [WCNT_W-1:0]   word_cnt_q;
  logic [SHIFT_W-1:0]  shift_q;
  axis_word_t          pending_q;
  logic                overflow_q;
  logic                frame_done_q;
  logic                resync_q;

  logic                frame_start_c;
  logic                has_space_c;
  logic                lane_last_c;
  logic                frame_last_c;
  logic                mismatch_c;
  axis_word_t          formed_word_c;
  logic                start_c;
  logic                accept_c;
  logic                push_c;
  axis_word_t          push_word_c;
  logic                pend_load_c;
  logic                drop_c;
  logic                done_c;
  logic                resync_c;

  logic [WORD_W:0]     fifo_head;
  logic                fifo_full;
  logic                fifo_empty;

  assign frame_start_c = pixel_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
  // A full buffer still has room when its head leaves in the same cycle.
  assign has_space_c   = !fifo_full || m_axis_ready;
  assign lane_last_c   = (lane_q == LANE_W'(PIX_PER_WORD - 1));
  assign frame_last_c  = (word_cnt_q == WCNT_W'(WORDS_PER_FRAME - 1));
  assign formed_word_c = '{last: frame_last_c, data: {pixel_in, shift_q}};

`ifdef CAMERA_PACKER_CHECK_EN
  logic [10:0] exp_h_q;
  logic [9:0]  exp_v_q;

  assign mismatch_c = (hcount_in != exp_h_q) || (vcount_in != exp_v_q);

  // Raster position the next in-frame pixel must carry.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      exp_h_q <= 11'd0;
      exp_v_q <= 10'd0;
    end else if (start_c) begin
      exp_h_q <= 11'd1;
      exp_v_q <= 10'd0;
    end else if (accept_c) begin
      if (exp_h_q == 11'(H_PIXELS - 1)) begin
        exp_h_q <= 11'd0;
        exp_v_q <= exp_v_q + 10'd1;
      end else begin
        exp_h_q <= exp_h_q + 11'd1;
      end
    end
  end
`else
  assign mismatch_c = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start_c) state_d = ST_PACK;
      end
      ST_PACK: begin
        if (pixel_valid_in) begin
          if (mismatch_c) begin
            state_d = frame_start_c ? ST_PACK : ST_IDLE;
          end else if (frame_start_c) begin
            state_d = ST_PACK;
          end else if (lane_last_c && frame_last_c) begin
            state_d = has_space_c ? ST_IDLE : ST_HOLD_LAST;
          end
        end
      end
      ST_HOLD_LAST: begin
        if (has_space_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: datapath strobes, buffer push and event flags.
  always_comb begin
    start_c     = 1'b0;
    accept_c    = 1'b0;
    push_c      = 1'b0;
    push_word_c = formed_word_c;
    pend_load_c = 1'b0;
    drop_c      = 1'b0;
    resync_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_c = frame_start_c;
      end
      ST_PACK: begin
        if (pixel_valid_in) begin
          if (mismatch_c) begin
            resync_c = 1'b1;
            start_c  = frame_start_c;
          end else if (frame_start_c) begin
            start_c = 1'b1;
          end else begin
            accept_c = 1'b1;
            if (lane_last_c) begin
              if (has_space_c)       push_c      = 1'b1;
              else if (frame_last_c) pend_load_c = 1'b1;
              else                   drop_c      = 1'b1;
            end
          end
        end
      end
      ST_HOLD_LAST: begin
        if (has_space_c) begin
          push_c      = 1'b1;
          push_word_c = pending_q;
        end
      end
      default: ;
    endcase
    done_c = push_c && push_word_c.last;
  end

  // Lane shift register, counters, pending word and status flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lane_q       <= '0;
      word_cnt_q   <= '0;
      shift_q      <= '0;
      pending_q    <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      resync_q     <= 1'b0;
    end else begin
      if (start_c || accept_c) shift_q <= {pixel_in, shift_q[SHIFT_W-1:PIX_W]};
      if (start_c) begin
        lane_q     <= LANE_W'(1);
        word_cnt_q <= '0;
      end else if (accept_c) begin
        lane_q <= lane_q + LANE_W'(1);
        if (lane_last_c) word_cnt_q <= word_cnt_q + WCNT_W'(1);
      end
      if (pend_load_c) pending_q <= formed_word_c;
      if (drop_c)      overflow_q <= 1'b1;
      frame_done_q <= done_c;
      resync_q     <= resync_c;
    end
  end

  word_fifo2 u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (push_c),
    .push_word (push_word_c),
    .pop       (m_axis_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_axis_valid   = !fifo_empty;
  assign m_axis_data    = fifo_head[WORD_W-1:0];
  assign m_axis_tlast   = fifo_head[WORD_W];
  assign overflow_out   = overflow_q;
  assign resync_out     = resync_q;
  assign frame_done_out = frame_done_q;

endmodule
